// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked adder.
//   - Default operand width and slice width.
//   - FSM state encoding used by the top-level controller.
package chunked_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-bit adder slice.
//   x, y  : slice operands
//   ci    : carry into the slice LSB
//   s     : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for signed overflow)
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] total;

    assign total = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    assign s     = total[CHUNK-1:0];
    assign co    = total[CHUNK];
    // The sum bit at the MSB is x ^ y ^ carry_in, so the incoming carry
    // is recovered without a second narrower adder (also valid for CHUNK=1).
    assign c_msb = s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock.
//   clk, rst         : clock and synchronous active-high reset
//   start            : begin a new operation (accepted in IDLE or DONE)
//   a, b, cin, sub   : operands, carry-in (add only) and mode (1 = a-b)
//   busy             : high while slices are being added
//   done             : one-cycle completion pulse
//   sum, cout, ovf   : registered result, MSB carry-out, signed overflow
// WIDTH must be an integer multiple of CHUNK.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A; completed slices enter at the top
    logic [WIDTH-1:0] b_q, b_d;       // operand B (already inverted for subtract)
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;
    logic [WIDTH-1:0] a_shifted;

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .x     (a_q[CHUNK-1:0]),
        .y     (b_q[CHUNK-1:0]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // Consumed A bits leave at the bottom while result slices fill from the
    // top, so after NCH shifts the A register holds the complete sum.
    assign a_shifted = (a_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_shifted;
                b_d     = b_q >> CHUNK;
                carry_d = slice_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    sum_d   = a_shifted;
                    cout_d  = slice_co;
                    ovf_d   = slice_c_msb ^ slice_co;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the operand registers are reset too; it costs little and
            // keeps the datapath free of X after reset.
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder at WIDTH=16, CHUNK=4.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] held_sum  = 16'h0000;
    logic        held_cout = 1'b0;
    logic        held_ovf  = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    chunked_adder dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [15:0] va, input logic [15:0] vb,
                               input logic vcin, input logic vsub);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vcin;
        sub   = vsub;
    endtask

    task automatic check_result(input string name, input logic [15:0] es,
                                input logic ec, input logic eo);
        check({name, " done"}, done, 1'b1);
        check({name, " busy"}, busy, 1'b0);
        check({name, " sum"},  sum,  es);
        check({name, " cout"}, cout, ec);
        check({name, " ovf"},  ovf,  eo);
        held_sum  = es;
        held_cout = ec;
        held_ovf  = eo;
    endtask

    // Check RUN-cycle status; the previous result must still be held.
    task automatic check_running(input string name);
        check({name, " busy"},     busy, 1'b1);
        check({name, " done"},     done, 1'b0);
        check({name, " sum hold"}, sum,  held_sum);
    endtask

    // Full operation starting in the current cycle (cycle 0); ends in cycle 6.
    task automatic run_vec(input vec_t v);
        drive_start(v.a, v.b, v.cin, v.sub);
        step();
        // Inputs are garbage from here on and must not affect the result.
        start = 1'b0;
        a     = ~v.a;
        b     = 16'h5A5A;
        cin   = ~v.cin;
        sub   = ~v.sub;
        for (int c = 1; c <= 4; c++) begin
            check_running(v.name);
            step();
        end
        check_result(v.name, v.e_sum, v.e_cout, v.e_ovf);
        step();
        check({v.name, " idle done"}, done, 1'b0);
        check({v.name, " idle busy"}, busy, 1'b0);
        check({v.name, " idle sum"},  sum,  held_sum);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"add_7fff_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"add_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{"sub_equal",     16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{"sub_cin_ign",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        vecs[8] = '{"add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        cin   = 1'b0;
        sub   = 1'b0;
        step();
        step();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sum",  sum,  16'h0000);
        check("reset cout", cout, 1'b0);
        check("reset ovf",  ovf,  1'b0);
        // Reset must win over start.
        start = 1'b1;
        step();
        check("reset prio busy", busy, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        step();
        check("idle busy", busy, 1'b0);
        check("idle done", done, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Second start in cycle 2 must be ignored.
        drive_start(16'h1234, 16'h4321, 1'b0, 1'b0);
        step();                                  // cycle 1
        start = 1'b0;
        check_running("ign c1");
        step();                                  // cycle 2
        check_running("ign c2");
        drive_start(16'hAAAA, 16'h1111, 1'b1, 1'b1);
        step();                                  // cycle 3
        start = 1'b0;
        check_running("ign c3");
        step();                                  // cycle 4
        check_running("ign c4");
        step();                                  // cycle 5
        check_result("ign", 16'h5555, 1'b0, 1'b0);
        step();
        check("ign after done", done, 1'b0);

        // Reset in cycle 3 aborts the run with no done pulse.
        drive_start(16'h00FF, 16'h0001, 1'b0, 1'b0);
        step();                                  // cycle 1
        start = 1'b0;
        step();                                  // cycle 2
        step();                                  // cycle 3
        rst = 1'b1;
        step();                                  // cycle 4
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort sum",  sum,  16'h0000);
        check("abort cout", cout, 1'b0);
        check("abort ovf",  ovf,  1'b0);
        held_sum  = 16'h0000;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("abort no done", done, 1'b0);
            check("abort no busy", busy, 1'b0);
            step();
        end
        run_vec('{"after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});

        // Start during DONE: back-to-back, second done five cycles later.
        drive_start(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check_running("b2b first");
            step();
        end
        check_result("b2b first", 16'h3333, 1'b0, 1'b0);
        drive_start(16'h4000, 16'h0001, 1'b0, 1'b1);
        step();                                  // cycle 6
        start = 1'b0;
        a     = 16'hFFFF;
        for (int c = 6; c <= 9; c++) begin
            check_running("b2b second");
            step();
        end
        check_result("b2b second", 16'h3FFF, 1'b1, 1'b0);
        step();
        check("b2b end done", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
